// File: rtl/multi_channel_mean_unit.sv
// multi_channel_mean_unit: accumulates NUM_CH parallel sample streams over a
// programmable window of N samples, then divides each channel sum by N on one
// shared restoring divider, giving unsigned Q(DATA_WIDTH).(FRAC_BITS) means.
// Optional build macro MEAN_UNIT_VARIANCE_EN adds per-channel sum-of-squares
// and a var_out port computed on the same divider after the mean phase.
module multi_channel_mean_unit #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_CH     = 3,
   parameter int unsigned CNT_WIDTH  = 20,
   parameter int unsigned FRAC_BITS  = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [CNT_WIDTH-1:0]           total_samples,
   input  logic                           start,
   input  logic [NUM_CH*DATA_WIDTH-1:0]   data_in,
   input  logic                           data_valid,
   output logic [NUM_CH*(DATA_WIDTH+FRAC_BITS)-1:0] mean_out,
   output logic                           ready,
   output logic                           busy,
   output logic                           err_zero
`ifdef MEAN_UNIT_VARIANCE_EN
   ,output logic [NUM_CH*2*DATA_WIDTH-1:0] var_out
`endif
);

   localparam int unsigned ACC_WIDTH = DATA_WIDTH + CNT_WIDTH;
   localparam int unsigned MW        = DATA_WIDTH + FRAC_BITS;
   localparam int unsigned CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef MEAN_UNIT_VARIANCE_EN
   localparam int unsigned VW        = 2 * DATA_WIDTH;
   localparam int unsigned SQ_WIDTH  = VW + CNT_WIDTH;
   localparam int unsigned SHW       = (MW > VW) ? MW : VW;
`else
   localparam int unsigned SHW       = MW;
`endif
   localparam int unsigned BCW       = $clog2(SHW + 1);

   typedef enum logic [1:0] {IDLE, ACCUM, DIV, DONE} state_t;

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   n_q;
   logic [CNT_WIDTH-1:0]   count_q;
   logic [ACC_WIDTH-1:0]   sum_q [NUM_CH];
   logic [CHW-1:0]         ch_idx_q;
   logic [BCW-1:0]         bit_cnt_q;
   logic [CNT_WIDTH-1:0]   rem_q;
   logic [SHW-1:0]         sh_q;
   logic                   ready_d, busy_d, err_d;
`ifdef MEAN_UNIT_VARIANCE_EN
   logic [SQ_WIDTH-1:0]    sumsq_q [NUM_CH];
   logic                   phase_q;
`endif

   logic [CNT_WIDTH-1:0]   init_rem_c, cur_rem_c, new_rem_c;
   logic [SHW-1:0]         init_sh_c, cur_sh_c, new_sh_c;
   logic [CNT_WIDTH:0]     trial_c;
   logic [BCW-1:0]         len_c;
   logic                   qbit_c, ch_last_c, div_last_c;

   // Divider step: operand is loaded combinationally on the first bit of each
   // channel, left-aligned so the next dividend bit is always the MSB of sh.
   always_comb begin
      len_c      = BCW'(MW);
      init_rem_c = CNT_WIDTH'(sum_q[ch_idx_q] >> DATA_WIDTH);
      init_sh_c  = SHW'({sum_q[ch_idx_q][DATA_WIDTH-1:0], FRAC_BITS'(0)}) << (SHW - MW);
`ifdef MEAN_UNIT_VARIANCE_EN
      if (phase_q) begin
         len_c      = BCW'(VW);
         init_rem_c = CNT_WIDTH'(sumsq_q[ch_idx_q] >> VW);
         init_sh_c  = SHW'(sumsq_q[ch_idx_q][VW-1:0]) << (SHW - VW);
      end
`endif
      cur_rem_c  = (bit_cnt_q == '0) ? init_rem_c : rem_q;
      cur_sh_c   = (bit_cnt_q == '0) ? init_sh_c  : sh_q;
      trial_c    = {cur_rem_c, cur_sh_c[SHW-1]};
      qbit_c     = (trial_c >= {1'b0, n_q});
      new_rem_c  = qbit_c ? CNT_WIDTH'(trial_c - {1'b0, n_q}) : CNT_WIDTH'(trial_c);
      new_sh_c   = {cur_sh_c[SHW-2:0], qbit_c};
      ch_last_c  = (bit_cnt_q == len_c - BCW'(1));
`ifdef MEAN_UNIT_VARIANCE_EN
      div_last_c = ch_last_c && (ch_idx_q == CHW'(NUM_CH - 1)) && phase_q;
`else
      div_last_c = ch_last_c && (ch_idx_q == CHW'(NUM_CH - 1));
`endif
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; start overrides every state
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = (total_samples == '0) ? DONE : ACCUM;
      end else begin
         case (state_q)
            ACCUM: if (data_valid && (count_q + CNT_WIDTH'(1) == n_q)) state_d = DIV;
            DIV:   if (div_last_c) state_d = DONE;
            default: ;
         endcase
      end
   end

   // Output logic: next values of the registered status flags
   always_comb begin
      ready_d = (state_d == DONE);
      busy_d  = (state_d == ACCUM) || (state_d == DIV);
      err_d   = err_zero;
      if (start) err_d = (total_samples == '0);
   end

   // Registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         ready    <= 1'b0;
         busy     <= 1'b0;
         err_zero <= 1'b0;
      end else begin
         ready    <= ready_d;
         busy     <= busy_d;
         err_zero <= err_d;
      end
   end

   // Datapath: accumulation, divider registers and result write-back
   always_ff @(posedge clk) begin
      if (rst) begin
         n_q       <= '0;
         count_q   <= '0;
         ch_idx_q  <= '0;
         bit_cnt_q <= '0;
         rem_q     <= '0;
         sh_q      <= '0;
         mean_out  <= '0;
         for (int c = 0; c < NUM_CH; c++) sum_q[c] <= '0;
`ifdef MEAN_UNIT_VARIANCE_EN
         phase_q   <= 1'b0;
         var_out   <= '0;
         for (int c = 0; c < NUM_CH; c++) sumsq_q[c] <= '0;
`endif
      end else if (start) begin
         n_q       <= total_samples;
         count_q   <= '0;
         ch_idx_q  <= '0;
         bit_cnt_q <= '0;
         for (int c = 0; c < NUM_CH; c++) sum_q[c] <= '0;
         if (total_samples == '0) mean_out <= '0;
`ifdef MEAN_UNIT_VARIANCE_EN
         phase_q   <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) sumsq_q[c] <= '0;
         if (total_samples == '0) var_out <= '0;
`endif
      end else if (state_q == ACCUM) begin
         if (data_valid) begin
            count_q <= count_q + CNT_WIDTH'(1);
            for (int c = 0; c < NUM_CH; c++) begin
               sum_q[c] <= sum_q[c] + ACC_WIDTH'(data_in[c*DATA_WIDTH +: DATA_WIDTH]);
`ifdef MEAN_UNIT_VARIANCE_EN
               sumsq_q[c] <= sumsq_q[c] + SQ_WIDTH'(VW'(data_in[c*DATA_WIDTH +: DATA_WIDTH]) *
                                                    VW'(data_in[c*DATA_WIDTH +: DATA_WIDTH]));
`endif
            end
         end
      end else if (state_q == DIV) begin
         rem_q <= new_rem_c;
         sh_q  <= new_sh_c;
         if (ch_last_c) begin
            bit_cnt_q <= '0;
`ifdef MEAN_UNIT_VARIANCE_EN
            if (phase_q) begin
               var_out[int'(ch_idx_q)*VW +: VW] <= new_sh_c[VW-1:0] -
                  VW'(mean_out[int'(ch_idx_q)*MW + FRAC_BITS +: DATA_WIDTH]) *
                  VW'(mean_out[int'(ch_idx_q)*MW + FRAC_BITS +: DATA_WIDTH]);
            end else begin
               mean_out[int'(ch_idx_q)*MW +: MW] <= new_sh_c[MW-1:0];
            end
            if (ch_idx_q == CHW'(NUM_CH - 1)) begin
               ch_idx_q <= '0;
               phase_q  <= 1'b1;
            end else begin
               ch_idx_q <= ch_idx_q + CHW'(1);
            end
`else
            mean_out[int'(ch_idx_q)*MW +: MW] <= new_sh_c[MW-1:0];
            if (ch_idx_q == CHW'(NUM_CH - 1)) ch_idx_q <= '0;
            else                              ch_idx_q <= ch_idx_q + CHW'(1);
`endif
         end else begin
            bit_cnt_q <= bit_cnt_q + BCW'(1);
         end
      end
   end

endmodule
